rx_packet_fifo: RTL and testbench

Single-clock packet buffer sitting directly downstream of the `axi_rx` serial deserializer on the `aclk` domain. It accepts full-width packets over the `fifo_data`/`fifo_valid`/`fifo_ready` handshake that `axi_rx` drives, stores up to 2^`depth_log2` packets, and presents them to the consumer over a valid/ready stream. It decouples bursty serial arrival from consumer stalls, so `axi_rx` never holds a finished packet waiting on the consumer.

---
 rtl/rx_packet_fifo.sv | 110 +++++++++++
 tb/tb_rx_packet_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_fifo.sv
// rx_packet_fifo: single-clock packet buffer between axi_rx and a valid/ready consumer.
// Latency: a packet written at edge N is presented on m_data/m_valid from cycle N+1.
// Backpressure: in_ready = not full, from registered level only; a read on a full cycle frees in_ready next cycle.
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   in_data/in_valid/in_ready   packet input from axi_rx (fifo_data/fifo_valid/fifo_ready)
//   m_data/m_valid/m_ready      head-of-queue output stream
//   level                packets currently stored (0..2^depth_log2)
//   stat_accepted        saturating count of accepted packets since reset
//   stat_hwm             highest level seen since reset
// Optional feature: define RX_FIFO_STATS_EN to build the statistics counters;
// without it stat_accepted and stat_hwm are tied to zero.
module rx_packet_fifo #(
    parameter int packet_length = 32,
    parameter int depth_log2    = 3
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [packet_length-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [packet_length-1:0] m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [depth_log2:0]      level,
    output logic [15:0]              stat_accepted,
    output logic [depth_log2:0]      stat_hwm
);

    localparam int depth = 1 << depth_log2;

    // Level value meaning "every slot occupied": only the top bit set.
    localparam logic [depth_log2:0]   full_level = {1'b1, {depth_log2{1'b0}}};
    localparam logic [depth_log2:0]   level_one  = {{depth_log2{1'b0}}, 1'b1};
    localparam logic [depth_log2-1:0] ptr_one    = {{(depth_log2-1){1'b0}}, 1'b1};

    logic [packet_length-1:0] mem [depth];
    logic [depth_log2-1:0]    wr_ptr;
    logic [depth_log2-1:0]    rd_ptr;
    logic [depth_log2:0]      level_q;
    logic                     wr_fire;
    logic                     rd_fire;

    // Both handshake qualifiers come from registered level, so there is no
    // combinational path from m_ready to in_ready.
    assign in_ready = (level_q != full_level);
    assign m_valid  = (level_q != '0);
    assign m_data   = mem[rd_ptr];
    assign level    = level_q;

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = m_valid && m_ready;

    // Storage is never reset; level gates visibility of stale contents.
    always_ff @(posedge aclk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + ptr_one;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + ptr_one;
            end
            // Simultaneous write and read leaves level unchanged.
            case ({wr_fire, rd_fire})
                2'b10:   level_q <= level_q + level_one;
                2'b01:   level_q <= level_q - level_one;
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef RX_FIFO_STATS_EN
    logic [15:0]         accepted_q;
    logic [depth_log2:0] hwm_q;

    // The high-water mark tracks the registered level, so it trails a new
    // peak by one cycle.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            accepted_q <= '0;
            hwm_q      <= '0;
        end else begin
            if (wr_fire && (accepted_q != 16'hFFFF)) begin
                accepted_q <= accepted_q + 16'd1;
            end
            if (level_q > hwm_q) begin
                hwm_q <= level_q;
            end
        end
    end

    assign stat_accepted = accepted_q;
    assign stat_hwm      = hwm_q;
`else
    assign stat_accepted = '0;
    assign stat_hwm      = '0;
`endif

endmodule

// File: tb/tb_rx_packet_fifo.sv
// tb_rx_packet_fifo: self-checking bench for rx_packet_fifo (depth 8, 32-bit packets).
// Checks a table of directed vectors, hand sequences for full/stream/reset/stats corners,
// and a randomized run against a queue-based reference model.
module tb_rx_packet_fifo;

    localparam int PL    = 32;
    localparam int DL2   = 3;
    localparam int DEPTH = 1 << DL2;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [PL-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [PL-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [DL2:0]  level;
    logic [15:0]   stat_accepted;
    logic [DL2:0]  stat_hwm;

    rx_packet_fifo #(.packet_length(PL), .depth_log2(DL2)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .level         (level),
        .stat_accepted (stat_accepted),
        .stat_hwm      (stat_hwm)
    );

    always #5 aclk = ~aclk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: contents as a queue plus plain statistics counters.
    logic [PL-1:0] model_q[$];
    int            model_acc = 0;
    int            model_hwm = 0;

    typedef struct {
        logic          iv;
        logic [PL-1:0] id;
        logic          mr;
        logic          exp_mv;
        logic          exp_ir;
        int            exp_lvl;
        logic          chk_dat;
        logic [PL-1:0] exp_dat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int exp_acc();
`ifdef RX_FIFO_STATS_EN
        return model_acc;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_hwm();
`ifdef RX_FIFO_STATS_EN
        return model_hwm;
`else
        return 0;
`endif
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".level"},    32'(level),    32'(model_q.size()));
        chk({tag, ".m_valid"},  32'(m_valid),  32'(model_q.size() != 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_q.size() != DEPTH));
        if (model_q.size() != 0) chk({tag, ".m_data"}, m_data, model_q[0]);
        chk({tag, ".stat_acc"}, 32'(stat_accepted), 32'(exp_acc()));
        chk({tag, ".stat_hwm"}, 32'(stat_hwm),      32'(exp_hwm()));
    endtask

    // One clock cycle: inputs are driven 1 time unit after an edge, outputs
    // sampled 1 time unit after the following edge.
    task automatic step(input logic iv, input logic [PL-1:0] id, input logic mr, input string tag);
        bit wf, rf;
        in_valid = iv;
        in_data  = id;
        m_ready  = mr;
        wf = iv && (model_q.size() < DEPTH);
        rf = mr && (model_q.size() > 0);
        if (model_q.size() > model_hwm) model_hwm = model_q.size();
        @(posedge aclk);
        #1;
        if (rf) void'(model_q.pop_front());
        if (wf) begin
            model_q.push_back(id);
            if (model_acc < 16'hFFFF) model_acc++;
        end
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        aresetn  = 1'b0;
        in_valid = 1'b0;
        m_ready  = 1'b0;
        in_data  = '0;
        @(posedge aclk);
        #1;
        model_q.delete();
        model_acc = 0;
        model_hwm = 0;
        chk({tag, ".rst_level"},    32'(level),         32'd0);
        chk({tag, ".rst_m_valid"},  32'(m_valid),       32'd0);
        chk({tag, ".rst_in_ready"}, 32'(in_ready),      32'd1);
        chk({tag, ".rst_stat_acc"}, 32'(stat_accepted), 32'd0);
        chk({tag, ".rst_stat_hwm"}, 32'(stat_hwm),      32'd0);
        aresetn = 1'b1;
    endtask

    function automatic vec_t mk(logic iv, logic [PL-1:0] id, logic mr, logic mv, logic ir,
                                int lvl, logic cd, logic [PL-1:0] d);
        vec_t v;
        v.iv = iv; v.id = id; v.mr = mr; v.exp_mv = mv; v.exp_ir = ir;
        v.exp_lvl = lvl; v.chk_dat = cd; v.exp_dat = d;
        return v;
    endfunction

    initial begin
        // Directed table: hold DEADBEEF, drain, then overfill and drain in order.
        vecs.push_back(mk(1, 32'hDEADBEEF, 0, 1, 1, 1, 1, 32'hDEADBEEF));
        for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 32'h0, 0, 1, 1, 1, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, 32'h0, 1, 0, 1, 0, 0, 32'h0));
        for (int k = 1; k <= 8; k++) vecs.push_back(mk(1, 32'(k), 0, 1, k != 8, k, 1, 32'd1));
        vecs.push_back(mk(1, 32'd9, 0, 1, 0, 8, 1, 32'd1));      // 9th waits while full
        vecs.push_back(mk(1, 32'd9, 1, 1, 1, 7, 1, 32'd2));      // read frees slot, ready next cycle
        vecs.push_back(mk(1, 32'd9, 0, 1, 0, 8, 1, 32'd2));      // pending write lands
        for (int j = 1; j <= 8; j++) vecs.push_back(mk(0, 32'h0, 1, j != 8, 1, 8 - j, j != 8, 32'(j + 2)));

        aresetn  = 1'b0;
        in_valid = 1'b0;
        m_ready  = 1'b0;
        in_data  = '0;
        #1;
        do_reset("init");

        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].id, vecs[i].mr, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_level", i),    32'(level),    32'(vecs[i].exp_lvl));
            chk($sformatf("vec%0d.tbl_m_valid", i),  32'(m_valid),  32'(vecs[i].exp_mv));
            chk($sformatf("vec%0d.tbl_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
            if (vecs[i].chk_dat) chk($sformatf("vec%0d.tbl_m_data", i), m_data, vecs[i].exp_dat);
        end

        // Sustained simultaneous push/pop at level 3.
        do_reset("stream");
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, "stream_fill");
        for (int i = 0; i < 100; i++) begin
            step(1, $urandom, 1, "stream");
            chk("stream.level3", 32'(level), 32'd3);
        end

        // Reset mid-operation at level 5, then a fresh push.
        do_reset("mid");
        for (int i = 0; i < 5; i++) step(1, 32'h100 + 32'(i), 0, "mid_fill");
        chk("mid.level5", 32'(level), 32'd5);
        do_reset("mid");
        step(1, 32'hA5A5A5A5, 0, "mid_push");
        chk("mid.push_data", m_data, 32'hA5A5A5A5);

        // Statistics: 12 accepted, peak level 7.
        do_reset("stats");
        for (int i = 0; i < 5; i++) step(1, $urandom, 0, "stats_a");
        for (int i = 0; i < 5; i++) step(0, '0, 1, "stats_b");
        for (int i = 0; i < 7; i++) step(1, $urandom, 0, "stats_c");
        step(0, '0, 0, "stats_idle");
`ifdef RX_FIFO_STATS_EN
        chk("stats.accepted12", 32'(stat_accepted), 32'd12);
        chk("stats.hwm7",       32'(stat_hwm),      32'd7);
`else
        chk("stats.accepted0", 32'(stat_accepted), 32'd0);
        chk("stats.hwm0",      32'(stat_hwm),      32'd0);
`endif

        // Randomized traffic in phases biased toward full, empty and balanced.
        do_reset("rand");
        for (int ph = 0; ph < 6; ph++) begin
            int pw, pr;
            pw = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 55;
            pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 55;
            for (int c = 0; c < 400; c++) begin
                step($urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < pr, "rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
